// File: rtl/fetch_next_pc.sv
// Fetch-side next-PC generator with a direct-mapped branch target buffer.
// Define BPRED_BTB_EN to build the BTB; otherwise fetch is purely sequential plus redirects.
module fetch_next_pc #(
    parameter int              ALEN        = 32,
    parameter logic [ALEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [ALEN-1:0] fetch_addr,
    output logic            fetch_pred_taken,
    input  logic            redirect_valid,
    input  logic [ALEN-1:0] redirect_addr,
    input  logic            update_valid,
    input  logic [ALEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [ALEN-1:0] update_target,
    input  logic            btb_flush
);

    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = ALEN - 1 - IDXW;
    localparam logic [ALEN-3:0] WORD_ONE = 1;

    logic [ALEN-1:0] pc;
    logic [ALEN-1:0] pc_next;
    logic [ALEN-1:0] seq_pc;
    logic [ALEN-1:0] redirect_pc;
    logic [ALEN-1:0] pred_target;
    logic            hit;

    // Fetch is word-granular: a halfword-aligned pc still advances to the next word.
    assign seq_pc      = {pc[ALEN-1:2] + WORD_ONE, 2'b00};
    assign redirect_pc = {redirect_addr[ALEN-1:1], 1'b0};

    assign fetch_valid      = !rst;
    assign fetch_addr       = pc;
    assign fetch_pred_taken = hit;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (fetch_valid && fetch_ready) begin
            pc_next = hit ? pred_target : seq_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef BPRED_BTB_EN
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [ALEN-2:0]        btb_target [BTB_ENTRIES];

    logic [IDXW-1:0] rd_idx;
    logic [TAGW-1:0] rd_tag;
    logic [IDXW-1:0] wr_idx;
    logic [TAGW-1:0] wr_tag;
    logic            wr_en;
    logic            unused_btb;

    assign rd_idx = pc[IDXW:1];
    assign rd_tag = pc[ALEN-1:IDXW+1];
    assign wr_idx = update_pc[IDXW:1];
    assign wr_tag = update_pc[ALEN-1:IDXW+1];
    assign wr_en  = !rst && !btb_flush && update_valid && update_taken;

    // Lookup sees the pre-write contents when training hits the same index this cycle.
    assign hit         = !rst && btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign pred_target = {btb_target[rd_idx], 1'b0};

    // Flush beats a same-cycle update; a not-taken update only kills its own tag.
    always_ff @(posedge clk) begin
        if (rst || btb_flush) begin
            btb_valid <= '0;
        end else if (update_valid) begin
            if (update_taken) begin
                btb_valid[wr_idx] <= 1'b1;
            end else if (btb_tag[wr_idx] == wr_tag) begin
                btb_valid[wr_idx] <= 1'b0;
            end
        end
    end

    // NOTE: tag/target storage has no reset; the valid bits alone decide whether an entry is live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            btb_tag[wr_idx]    <= wr_tag;
            btb_target[wr_idx] <= update_target[ALEN-1:1];
        end
    end

    assign unused_btb = ^{redirect_addr[0], update_pc[0], update_target[0]};
`else
    logic unused_btb;

    assign hit         = 1'b0;
    assign pred_target = '0;
    assign unused_btb  = ^{redirect_addr[0], update_valid, update_pc, update_taken,
                           update_target, btb_flush};
`endif

endmodule

// File: tb/tb_fetch_next_pc.sv
// Randomized self-checking bench for fetch_next_pc against an address-level reference model.
// Honours BPRED_BTB_EN the same way as the design build.
module tb_fetch_next_pc;

    localparam int          N        = 32;
    localparam int          IDXW     = $clog2(N);
    localparam logic [31:0] RESET_PC = 32'h1000;
`ifdef BPRED_BTB_EN
    localparam bit BTB_EN = 1'b1;
`else
    localparam bit BTB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic        fetch_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        btb_flush;

    fetch_next_pc #(
        .ALEN        (32),
        .RESET_PC    (RESET_PC),
        .BTB_ENTRIES (N)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_addr       (fetch_addr),
        .fetch_pred_taken (fetch_pred_taken),
        .redirect_valid   (redirect_valid),
        .redirect_addr    (redirect_addr),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .btb_flush        (btb_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: each slot remembers the full branch address it was trained with.
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_bpc   [N];
    logic [31:0] m_tgt   [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 1) % N);
    endfunction

    function automatic bit same_region(input logic [31:0] a, input logic [31:0] b);
        return (a >> (IDXW + 1)) == (b >> (IDXW + 1));
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s;
        s = slot(a);
        return BTB_EN && m_valid[s] && same_region(m_bpc[s], a);
    endfunction

    // Advance one clock: predict the next state from the current inputs, then compare.
    task automatic tick();
        logic [31:0] nxt;
        int          s;
        if (rst)                 nxt = RESET_PC;
        else if (redirect_valid) nxt = redirect_addr & ~32'h1;
        else if (fetch_ready)    nxt = m_hit(m_pc) ? (m_tgt[slot(m_pc)] & ~32'h1)
                                                   : ((m_pc & ~32'h3) + 32'd4);
        else                     nxt = m_pc;

        if (rst || btb_flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        end else if (update_valid) begin
            s = slot(update_pc);
            if (update_taken) begin
                m_valid[s] = 1'b1;
                m_bpc[s]   = update_pc;
                m_tgt[s]   = update_target;
            end else if (same_region(m_bpc[s], update_pc)) begin
                m_valid[s] = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        m_pc = nxt;
        check("addr", fetch_addr, m_pc);
        check("valid", 32'(fetch_valid), 32'(!rst));
        check("pred", 32'(fetch_pred_taken), 32'(!rst && m_hit(m_pc)));
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        update_valid   = 1'b0;
        update_taken   = 1'b0;
        btb_flush      = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] p, input bit taken, input logic [31:0] t);
        update_valid  = 1'b1;
        update_pc     = p;
        update_taken  = taken;
        update_target = t;
        tick();
        update_valid  = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0, 1, 2: a = 32'h1000 + 32'($urandom_range(0, 63) << 1);
            3:       a = 32'h1000 + 32'($urandom_range(0, 3) * (4 * N)) + 32'($urandom_range(0, 15) << 1);
            4:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: a = $urandom;
        endcase
        return a;
    endfunction

    initial begin
        rst           = 1'b1;
        fetch_ready   = 1'b1;
        redirect_addr = '0;
        update_pc     = '0;
        update_target = '0;
        idle_inputs();

        // Reset and sequential fetch.
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_addr", fetch_addr, RESET_PC);
        check("rst_valid", 32'(fetch_valid), 32'd1);
        check("rst_pred", 32'(fetch_pred_taken), 32'd0);
        tick();
        check("seq_1004", fetch_addr, 32'h1004);
        tick();
        check("seq_1008", fetch_addr, 32'h1008);

        // Back-pressure holds the address.
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_1008", fetch_addr, 32'h1008);
        end
        fetch_ready = 1'b1;
        tick();
        check("resume_100c", fetch_addr, 32'h100C);

        // Train a taken branch and refetch it.
        do_update(32'h1004, 1'b1, 32'h2000);
        do_redirect(32'h1004);
        check("train_pred", 32'(fetch_pred_taken), 32'(BTB_EN));
        tick();
        check("train_next", fetch_addr, BTB_EN ? 32'h2000 : 32'h1008);

        // Redirect ignores fetch_ready.
        fetch_ready = 1'b0;
        do_redirect(32'h3002);
        check("redir_addr", fetch_addr, 32'h3002);
        check("redir_valid", 32'(fetch_valid), 32'd1);
        fetch_ready = 1'b1;
        tick();
        check("redir_seq", fetch_addr, 32'h3004);

        // Not-taken invalidates; an aliasing not-taken leaves the entry alone.
        do_update(32'h1004, 1'b0, 32'h0);
        do_redirect(32'h1004);
        check("nt_miss", 32'(fetch_pred_taken), 32'd0);
        do_update(32'h1004, 1'b1, 32'h2000);
        do_update(32'h1004 + 32'(2 * N * 2), 1'b0, 32'h0);
        do_redirect(32'h1004);
        check("alias_keep", 32'(fetch_pred_taken), 32'(BTB_EN));

        // Flush beats a same-cycle taken update.
        btb_flush = 1'b1;
        do_update(32'h1004, 1'b1, 32'h2000);
        btb_flush = 1'b0;
        do_redirect(32'h1004);
        check("flush_miss", 32'(fetch_pred_taken), 32'd0);

        // Reset mid-redirect drops everything in flight.
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h5000;
        do_update(32'h1004, 1'b1, 32'h2000);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_mid_addr", fetch_addr, RESET_PC);
        do_redirect(32'h1004);
        check("rst_drop_upd", 32'(fetch_pred_taken), 32'd0);

        // Sequential adder wraps at the top of the address space.
        do_redirect(32'hFFFF_FFFC);
        tick();
        check("wrap_zero", fetch_addr, 32'h0);

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst            = ($urandom_range(0, 99) == 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_addr  = pick_addr();
            update_valid   = ($urandom_range(0, 3) == 0);
            update_pc      = pick_addr();
            update_taken   = ($urandom_range(0, 2) != 0);
            update_target  = pick_addr();
            btb_flush      = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
